// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core: widths, NOP encoding, instruction field
// accessors used by decode, and the fetch stage debug view.
package core_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] NOP_INSTR = 8'h00;

    // Fetch stage operating states, exposed for observation only.
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    typedef struct packed {
        logic [1:0] state;
        logic       pc_in_imem;
    } fetch_dbg_t;

    function automatic logic [1:0] instr_op(input logic [DATA_W-1:0] instr);
        return instr[7:6];
    endfunction

    function automatic logic [1:0] instr_rs(input logic [DATA_W-1:0] instr);
        return instr[5:4];
    endfunction

    function automatic logic [1:0] instr_rt(input logic [DATA_W-1:0] instr);
        return instr[3:2];
    endfunction

    function automatic logic [1:0] instr_rd_imm(input logic [DATA_W-1:0] instr);
        return instr[1:0];
    endfunction

endpackage

// File: rtl/fetch_unit_program_counter.sv
// Program counter for the fetch stage: redirect load, sequential advance, hold.
module program_counter
    import core_pkg::*;
#(
    parameter int                ADDR_W   = core_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc
);

    // Redirect wins over advance; the increment wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_target;
        end else if (advance) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads IMEM and holds the IF/ID register.
// Optional out-of-range fetch detection is built when FETCH_ADDR_CHECK_EN is defined.
module fetch_unit
    import core_pkg::*;
#(
    parameter int                   ADDR_W     = core_pkg::ADDR_W,
    parameter int                   DATA_W     = core_pkg::DATA_W,
    parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
    parameter int unsigned          IMEM_WORDS = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    output logic [ADDR_W-1:0] Read_Address,
    input  logic [DATA_W-1:0] Instruction_In,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] IR_PC,
    output logic              IR_Valid,
    input  logic              Dec_Ready,
    input  logic              Redirect_Valid,
    input  logic [ADDR_W-1:0] Redirect_Target,
    input  logic              Halt,
    output logic              Fetch_Fault,
    output fetch_dbg_t        Fetch_Dbg
);

    localparam logic [ADDR_W:0] IMEM_LIMIT = (ADDR_W+1)'(IMEM_WORDS);

    logic [ADDR_W-1:0] pc;
    logic              slot_free;
    logic              fetch;
    logic              pc_in_imem;

    // Handshake: IR transfers to decode on a rising edge where IR_Valid=1 and
    // Dec_Ready=1; while IR_Valid=1 and Dec_Ready=0, IR and IR_PC hold steady.
    assign slot_free    = !IR_Valid || Dec_Ready;
    assign pc_in_imem   = {1'b0, pc} < IMEM_LIMIT;
    assign Read_Address = pc;

`ifdef FETCH_ADDR_CHECK_EN
    logic fetch_try;
    logic fault_set;

    assign fetch_try = slot_free && !Halt && !Redirect_Valid && !Fetch_Fault;
    assign fault_set = fetch_try && !pc_in_imem;
    assign fetch     = fetch_try && pc_in_imem;

    // Sticky until a redirect supplies a new PC.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Fetch_Fault <= 1'b0;
        end else if (Redirect_Valid) begin
            Fetch_Fault <= 1'b0;
        end else if (fault_set) begin
            Fetch_Fault <= 1'b1;
        end
    end
`else
    assign fetch       = slot_free && !Halt && !Redirect_Valid;
    assign Fetch_Fault = 1'b0;
`endif

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk             (Clk),
        .rst_n           (Reset_n),
        .redirect_valid  (Redirect_Valid),
        .redirect_target (Redirect_Target),
        .advance         (fetch),
        .pc              (pc)
    );

    // A redirect drops IR even mid-stall; IR contents are left as they were.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            IR       <= DATA_W'(NOP_INSTR);
            IR_PC    <= '0;
            IR_Valid <= 1'b0;
        end else if (Redirect_Valid) begin
            IR_Valid <= 1'b0;
        end else if (fetch) begin
            IR       <= Instruction_In;
            IR_PC    <= pc;
            IR_Valid <= 1'b1;
        end else if (slot_free) begin
            IR_Valid <= 1'b0;
        end
    end

    always_comb begin
        Fetch_Dbg            = '0;
        Fetch_Dbg.pc_in_imem = pc_in_imem;
        if (Fetch_Fault) begin
            Fetch_Dbg.state = ST_FAULT;
        end else if (Halt) begin
            Fetch_Dbg.state = ST_HALTED;
        end else if (!slot_free) begin
            Fetch_Dbg.state = ST_STALL;
        end else begin
            Fetch_Dbg.state = ST_RUN;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// cycle-level reference model and an in-order delivery scoreboard.
module tb_fetch_unit;
    import core_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] Read_Address;
    logic [7:0] Instruction_In;
    logic [7:0] IR;
    logic [7:0] IR_PC;
    logic       IR_Valid;
    logic       Dec_Ready = 1'b0;
    logic       Redirect_Valid = 1'b0;
    logic [7:0] Redirect_Target = 8'h00;
    logic       Halt = 1'b0;
    logic       Fetch_Fault;
    fetch_dbg_t Fetch_Dbg;

    logic [7:0] imem [256];

    int tests_run = 0;
    int tests_failed = 0;

    // clock / reset
    always #5 Clk = ~Clk;

    assign Instruction_In = imem[Read_Address];

    fetch_unit dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .Read_Address    (Read_Address),
        .Instruction_In  (Instruction_In),
        .IR              (IR),
        .IR_PC           (IR_PC),
        .IR_Valid        (IR_Valid),
        .Dec_Ready       (Dec_Ready),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_Target (Redirect_Target),
        .Halt            (Halt),
        .Fetch_Fault     (Fetch_Fault),
        .Fetch_Dbg       (Fetch_Dbg)
    );

    // driver tasks
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Dec_Ready       = 1'b0;
        Redirect_Valid  = 1'b0;
        Redirect_Target = 8'h00;
        Halt            = 1'b0;
        Reset_n         = 1'b0;
        #7;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        #12;
        tests_run++;
        if (Read_Address !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_addr: got %h expected 00", Read_Address);
        end
        tests_run++;
        if (IR_Valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b expected 0", IR_Valid);
        end
        tests_run++;
        if (IR !== 8'h00 || IR_PC !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ir: got IR=%h IR_PC=%h expected 00/00", IR, IR_PC);
        end
        tests_run++;
        if (Fetch_Fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_fault: got %b expected 0", Fetch_Fault);
        end
        do_reset();
        Dec_Ready = 1'b1;
        step();
        tests_run++;
        if (IR_Valid !== 1'b1 || IR !== imem[0] || IR_PC !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_first_fetch: got v=%b IR=%h IR_PC=%h expected 1/%h/00",
                     IR_Valid, IR, IR_PC, imem[0]);
        end
    endtask

    task automatic test_stream();
        do_reset();
        Dec_Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (IR_Valid !== 1'b1 || IR_PC !== 8'(i) || IR !== imem[i]) begin
                tests_failed++;
                $display("FAIL stream_%0d: got v=%b IR_PC=%h IR=%h expected 1/%h/%h",
                         i, IR_Valid, IR_PC, IR, 8'(i), imem[i]);
            end
        end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        Dec_Ready = 1'b1;
        repeat (3) step();
        Dec_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (IR_Valid !== 1'b1 || IR_PC !== 8'h02 || IR !== imem[2] || Read_Address !== 8'h03) begin
                tests_failed++;
                $display("FAIL stall_%0d: got v=%b IR_PC=%h IR=%h addr=%h expected 1/02/%h/03",
                         i, IR_Valid, IR_PC, IR, Read_Address, imem[2]);
            end
        end
        tests_run++;
        if (Fetch_Dbg.state !== ST_STALL) begin
            tests_failed++;
            $display("FAIL stall_state: got %0d expected %0d", Fetch_Dbg.state, ST_STALL);
        end
        Dec_Ready = 1'b1;
        step();
        tests_run++;
        if (IR_Valid !== 1'b1 || IR_PC !== 8'h03) begin
            tests_failed++;
            $display("FAIL stall_release: got v=%b IR_PC=%h expected 1/03", IR_Valid, IR_PC);
        end
        // hold decode off again, then redirect out of the stall
        Dec_Ready = 1'b0;
        step();
        Redirect_Valid  = 1'b1;
        Redirect_Target = 8'h10;
        step();
        Redirect_Valid = 1'b0;
        tests_run++;
        if (IR_Valid !== 1'b0 || Read_Address !== 8'h10) begin
            tests_failed++;
            $display("FAIL redirect_flush: got v=%b addr=%h expected 0/10", IR_Valid, Read_Address);
        end
        step();
        tests_run++;
        if (IR_Valid !== 1'b1 || IR_PC !== 8'h10 || IR !== imem[16]) begin
            tests_failed++;
            $display("FAIL redirect_target: got v=%b IR_PC=%h IR=%h expected 1/10/%h",
                     IR_Valid, IR_PC, IR, imem[16]);
        end
    endtask

    task automatic test_halt_wrap();
        do_reset();
        Dec_Ready = 1'b1;
        repeat (2) step();
        Halt      = 1'b1;
        Dec_Ready = 1'b0;
        step();
        tests_run++;
        if (IR_Valid !== 1'b1 || IR_PC !== 8'h01 || Read_Address !== 8'h02) begin
            tests_failed++;
            $display("FAIL halt_hold: got v=%b IR_PC=%h addr=%h expected 1/01/02",
                     IR_Valid, IR_PC, Read_Address);
        end
        Dec_Ready = 1'b1;
        repeat (2) step();
        tests_run++;
        if (IR_Valid !== 1'b0 || Read_Address !== 8'h02 || Fetch_Dbg.state !== ST_HALTED) begin
            tests_failed++;
            $display("FAIL halt_drain: got v=%b addr=%h state=%0d expected 0/02/%0d",
                     IR_Valid, Read_Address, Fetch_Dbg.state, ST_HALTED);
        end
        Halt = 1'b0;
        step();
        tests_run++;
        if (IR_Valid !== 1'b1 || IR_PC !== 8'h02) begin
            tests_failed++;
            $display("FAIL halt_resume: got v=%b IR_PC=%h expected 1/02", IR_Valid, IR_PC);
        end
        Redirect_Valid  = 1'b1;
        Redirect_Target = 8'hFF;
        step();
        Redirect_Valid = 1'b0;
        step();
        tests_run++;
        if (IR_Valid !== 1'b1 || IR_PC !== 8'hFF || IR !== imem[255] || Read_Address !== 8'h00) begin
            tests_failed++;
            $display("FAIL wrap_ff: got v=%b IR_PC=%h IR=%h addr=%h expected 1/ff/%h/00",
                     IR_Valid, IR_PC, IR, Read_Address, imem[255]);
        end
        step();
        tests_run++;
        if (IR_Valid !== 1'b1 || IR_PC !== 8'h00 || IR !== imem[0]) begin
            tests_failed++;
            $display("FAIL wrap_00: got v=%b IR_PC=%h IR=%h expected 1/00/%h",
                     IR_Valid, IR_PC, IR, imem[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        Dec_Ready       = 1'b1;
        step();
        Redirect_Valid  = 1'b1;
        Redirect_Target = 8'h14;
        step();
        Redirect_Target = 8'h1C;
        step();
        Redirect_Valid = 1'b0;
        tests_run++;
        if (IR_Valid !== 1'b0 || Read_Address !== 8'h1C) begin
            tests_failed++;
            $display("FAIL b2b_redirect: got v=%b addr=%h expected 0/1c", IR_Valid, Read_Address);
        end
        step();
        tests_run++;
        if (IR_Valid !== 1'b1 || IR_PC !== 8'h1C) begin
            tests_failed++;
            $display("FAIL b2b_target: got v=%b IR_PC=%h expected 1/1c", IR_Valid, IR_PC);
        end
    endtask

`ifdef FETCH_ADDR_CHECK_EN
    task automatic test_fault();
        do_reset();
        Dec_Ready       = 1'b1;
        Redirect_Valid  = 1'b1;
        Redirect_Target = 8'd32;
        step();
        Redirect_Valid = 1'b0;
        step();
        tests_run++;
        if (Fetch_Fault !== 1'b1 || IR_Valid !== 1'b0 || Read_Address !== 8'd32) begin
            tests_failed++;
            $display("FAIL fault_set: got f=%b v=%b addr=%h expected 1/0/20",
                     Fetch_Fault, IR_Valid, Read_Address);
        end
        step();
        tests_run++;
        if (Fetch_Fault !== 1'b1 || IR_Valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_sticky: got f=%b v=%b expected 1/0", Fetch_Fault, IR_Valid);
        end
        Redirect_Valid  = 1'b1;
        Redirect_Target = 8'd4;
        step();
        Redirect_Valid = 1'b0;
        tests_run++;
        if (Fetch_Fault !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_clear: got %b expected 0", Fetch_Fault);
        end
        step();
        tests_run++;
        if (IR_Valid !== 1'b1 || IR_PC !== 8'd4) begin
            tests_failed++;
            $display("FAIL fault_recover: got v=%b IR_PC=%h expected 1/04", IR_Valid, IR_PC);
        end
    endtask
`endif

    // Randomized run: model tracks the PC and IF/ID contents from the
    // behavioural rules; exp_q holds fetched addresses awaiting decode.
    task automatic test_random(input int cycles);
        logic [7:0] exp_q[$];
        logic [7:0] m_pc;
        logic [7:0] m_ir_pc;
        logic       m_valid;
        logic       m_fault;
        logic       rv, hl, rdy, free;
        logic [7:0] tgt;
        logic [7:0] head;
        do_reset();
        m_pc    = 8'h00;
        m_ir_pc = 8'h00;
        m_valid = 1'b0;
        m_fault = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            rv  = ($urandom_range(0, 9) == 0);
`ifdef FETCH_ADDR_CHECK_EN
            tgt = 8'($urandom_range(0, 47));
`else
            tgt = 8'($urandom_range(0, 255));
`endif
            hl  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            Redirect_Valid  = rv;
            Redirect_Target = tgt;
            Halt            = hl;
            Dec_Ready       = rdy;
            #1;
            free = !m_valid || rdy;
            if (m_valid && rdy && !rv) begin
                head = exp_q.pop_front();
                tests_run++;
                if (IR_PC !== head) begin
                    tests_failed++;
                    $display("FAIL rand_consume_%0d: got IR_PC=%h expected %h", c, IR_PC, head);
                end
            end
            if (rv) begin
                m_pc    = tgt;
                m_valid = 1'b0;
                m_fault = 1'b0;
                exp_q.delete();
            end else if (free && !hl && !m_fault) begin
`ifdef FETCH_ADDR_CHECK_EN
                if (m_pc >= 8'd32) begin
                    m_fault = 1'b1;
                    m_valid = 1'b0;
                end else begin
                    m_ir_pc = m_pc;
                    m_valid = 1'b1;
                    exp_q.push_back(m_pc);
                    m_pc    = m_pc + 8'd1;
                end
`else
                m_ir_pc = m_pc;
                m_valid = 1'b1;
                exp_q.push_back(m_pc);
                m_pc    = m_pc + 8'd1;
`endif
            end else if (free) begin
                m_valid = 1'b0;
            end
            step();
            tests_run++;
            if (Read_Address !== m_pc || IR_Valid !== m_valid || Fetch_Fault !== m_fault) begin
                tests_failed++;
                $display("FAIL rand_state_%0d: got addr=%h v=%b f=%b expected %h/%b/%b",
                         c, Read_Address, IR_Valid, Fetch_Fault, m_pc, m_valid, m_fault);
            end
            if (m_valid) begin
                tests_run++;
                if (IR_PC !== m_ir_pc || IR !== imem[m_ir_pc]) begin
                    tests_failed++;
                    $display("FAIL rand_ir_%0d: got IR_PC=%h IR=%h expected %h/%h",
                             c, IR_PC, IR, m_ir_pc, imem[m_ir_pc]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] = 8'($urandom_range(0, 255));
        end
        test_reset();
        test_stream();
        test_stall_redirect();
        test_halt_wrap();
        test_back_to_back();
`ifdef FETCH_ADDR_CHECK_EN
        test_fault();
`endif
        test_random(400);
        // reset asserted mid-stream must return to the reset state immediately
        Dec_Ready = 1'b1;
        #2;
        Reset_n = 1'b0;
        #1;
        tests_run++;
        if (Read_Address !== 8'h00 || IR_Valid !== 1'b0 || IR !== 8'h00 || IR_PC !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_reset: got addr=%h v=%b IR=%h IR_PC=%h expected 00/0/00/00",
                     Read_Address, IR_Valid, IR, IR_PC);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
